// File: rtl/stim_pattern_gen_pkg.sv
// Shared definitions for the stimulus pattern generator.
// Contents:
//   mode_e        - pattern source encodings latched at start
//   state_e       - sequencing FSM states
//   SEED_DEFAULT  - default LFSR seed
//   LFSR_TAPS     - feedback tap mask (bits 0,2,3,5) for the 16-bit LFSR
//   lfsr_step()   - one advance of the right-shifting LFSR
package stim_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_LFSR = 2'd1,
    MODE_WALK = 2'd2,
    MODE_ZERO = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;

  // Feedback is the XOR of the tapped bits, shifted in at the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/stim_pattern_gen_if.sv
// Vector stream interface between the stimulus generator and its consumer.
// Signals:
//   out_valid  - current vector is valid (master drives)
//   out_ready  - consumer accepts the current vector (slave drives)
//   in_a/b/c   - vector fields, {in_a,in_b,in_c} forms the pattern word
// Modports: master (generator side), slave (consumer side).
interface stim_pattern_gen_if #(
  parameter int A_W = 3
);

  logic           out_valid;
  logic           out_ready;
  logic [A_W-1:0] in_a;
  logic           in_b;
  logic           in_c;

  modport master (
    output out_valid, in_a, in_b, in_c,
    input  out_ready
  );

  modport slave (
    input  out_valid, in_a, in_b, in_c,
    output out_ready
  );

endinterface

// File: rtl/stim_lfsr16.sv
// 16-bit right-shifting Fibonacci LFSR.
// Ports:
//   clk      - rising-edge clock
//   reset_1  - asynchronous active-low reset, state returns to SEED
//   load     - synchronous reload of SEED (has priority over adv)
//   adv      - advance one step
//   state    - current LFSR contents
module stim_lfsr16
  import stim_pattern_gen_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_1,
  input  logic        load,
  input  logic        adv,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (adv) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/stim_pattern_gen.sv
// Stimulus pattern generator: emits num_vec vectors {in_a,in_b,in_c} on a
// valid/ready stream, sourced from an incrementing count, an LFSR, a
// walking one, or all-zero.
// Ports:
//   clk, reset_1     - clock and asynchronous active-low reset
//   start            - begin a run (honoured only while idle)
//   num_vec, mode    - run length and pattern source, latched at start
//   vec              - vector stream (master side)
//   busy             - run in progress
//   done             - one-cycle pulse at end of run
//   vec_cnt          - handshakes completed in the current or last run
module stim_pattern_gen
  import stim_pattern_gen_pkg::*;
#(
  parameter int          A_W   = 3,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_1,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [1:0]       mode,
  stim_pattern_gen_if.master vec,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam int             P_W       = A_W + 2;
  localparam logic [P_W-1:0] WALK_INIT = P_W'(1);

  state_e           state, state_n;
  logic             valid, valid_n;
  logic [P_W-1:0]   pat, pat_n;
  logic             busy_n, done_n;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] num_lat, num_n;
  mode_e            mode_lat, mode_n;
  // One-hot walking position, rotated per handshake so the walk needs no
  // modulo of the index.
  logic [P_W-1:0]   walk, walk_n;
  logic             lfsr_load, lfsr_adv;
  logic [15:0]      lfsr_state;

  stim_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_1 (reset_1),
    .load    (lfsr_load),
    .adv     (lfsr_adv),
    .state   (lfsr_state)
  );

  function automatic logic [P_W-1:0] pattern(input mode_e m,
                                             input logic [CNT_W-1:0] idx,
                                             input logic [15:0] l,
                                             input logic [P_W-1:0] w);
    logic [P_W-1:0] p;
    case (m)
      MODE_INC:  p = idx[P_W-1:0];
      MODE_LFSR: p = l[P_W-1:0];
      MODE_WALK: p = w;
      default:   p = '0;
    endcase
    return p;
  endfunction

  always_comb begin
    state_n   = state;
    valid_n   = valid;
    pat_n     = pat;
    busy_n    = busy;
    done_n    = 1'b0;
    cnt_n     = vec_cnt;
    num_n     = num_lat;
    mode_n    = mode_lat;
    walk_n    = walk;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          cnt_n     = '0;
          if (num_vec == '0) begin
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            num_n   = num_vec;
            mode_n  = mode_e'(mode);
            walk_n  = WALK_INIT;
            pat_n   = pattern(mode_e'(mode), '0, SEED, WALK_INIT);
            valid_n = 1'b1;
            busy_n  = 1'b1;
            state_n = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (valid && vec.out_ready) begin
          lfsr_adv = 1'b1;
          cnt_n    = vec_cnt + 1'b1;
          walk_n   = {walk[P_W-2:0], walk[P_W-1]};
          if (cnt_n == num_lat) begin
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = ST_DONE;
          end else begin
            // Next vector loads on the same edge: back-to-back transfers.
            pat_n = pattern(mode_lat, cnt_n, lfsr_step(lfsr_state), walk_n);
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      state    <= ST_IDLE;
      valid    <= 1'b0;
      pat      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      vec_cnt  <= '0;
      num_lat  <= '0;
      mode_lat <= MODE_INC;
      walk     <= WALK_INIT;
    end else begin
      state    <= state_n;
      valid    <= valid_n;
      pat      <= pat_n;
      busy     <= busy_n;
      done     <= done_n;
      vec_cnt  <= cnt_n;
      num_lat  <= num_n;
      mode_lat <= mode_n;
      walk     <= walk_n;
    end
  end

  assign vec.out_valid = valid;
  assign {vec.in_a, vec.in_b, vec.in_c} = pat;

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Testbench for stim_pattern_gen: directed runs checked against a
// behavioural model of the expected vector sequence.
module tb_stim_pattern_gen;

  logic        clk;
  logic        reset_1;
  logic        start;
  logic [15:0] num_vec;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] vec_cnt;

  stim_pattern_gen_if #(.A_W(3)) bus ();

  stim_pattern_gen #(.A_W(3), .CNT_W(16), .SEED(16'hACE1)) dut (
    .clk     (clk),
    .reset_1 (reset_1),
    .start   (start),
    .num_vec (num_vec),
    .mode    (mode),
    .vec     (bus),
    .busy    (busy),
    .done    (done),
    .vec_cnt (vec_cnt)
  );

  int tests = 0;
  int fails = 0;

  logic [4:0] exp_q[$];
  int         hs_cnt    = 0;
  int         done_cnt  = 0;
  bit         exp_done  = 0;
  bit         prev_done = 0;

  logic [4:0] p_word;
  assign p_word = {bus.in_a, bus.in_b, bus.in_c};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Expected vector sequence for a run, from the pattern rules directly.
  task automatic build_exp(input int md, input int n);
    logic [15:0] l;
    logic [4:0]  p;
    l = 16'hACE1;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      case (md)
        0:       p = 5'(k % 32);
        1:       p = l[4:0];
        2:       p = 5'(1 << (k % 5));
        default: p = 5'd0;
      endcase
      exp_q.push_back(p);
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    end
  endtask

  // Per-cycle checker against the model queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_1) begin
        chk("busy_eq_valid", 32'(busy), 32'(bus.out_valid));
        if (exp_done) begin
          chk("done_after_last", 32'(done), 32'd1);
          exp_done = 0;
        end
        if (prev_done) chk("done_one_cycle", 32'(done), 32'd0);
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            chk("extra_vector", 32'(bus.out_valid), 32'd0);
          end else begin
            chk("pattern", 32'(p_word), 32'(exp_q[0]));
            chk("vec_cnt_run", 32'(vec_cnt), 32'(hs_cnt));
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              hs_cnt++;
              if (exp_q.size() == 0) exp_done = 1;
            end
          end
        end
        if (done) done_cnt++;
        prev_done = done;
      end
    end
  end

  // rpat 0: ready always high; rpat 1: ready 1,0,0 repeating.
  // inj >= 0: pulse a conflicting start on that cycle of the run.
  task automatic run(input int md, input int n, input int rpat, input int inj);
    int d0;
    int ph;
    bit got;
    build_exp(md, n);
    hs_cnt    = 0;
    d0        = done_cnt;
    start     = 1'b1;
    mode      = 2'(md);
    num_vec   = 16'(n);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    num_vec = 16'd1;
    mode    = 2'd3;
    chk("valid_latency", 32'(bus.out_valid), 32'(n != 0));
    got = done;
    ph  = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      bus.out_ready = (rpat == 0) ? 1'b1 : ((ph % 3) == 0);
      ph++;
      start = (c == inj);
      @(posedge clk); #1;
      start = 1'b0;
      if (done) got = 1;
    end
    chk("done_seen", 32'(got), 32'd1);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("vec_cnt_final", 32'(vec_cnt), 32'(n));
    chk("handshakes", 32'(hs_cnt), 32'(n));
    chk("vectors_left", 32'(exp_q.size()), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit hit;
    reset_1 = 1'b0;
    start   = 1'b0;
    num_vec = '0;
    mode    = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_word", 32'(p_word), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    #5 reset_1 = 1'b1;
    @(posedge clk); #1;

    // Model pins against hand-computed sequences.
    build_exp(1, 3);
    chk("model_lfsr0", 32'(exp_q[0]), 32'h01);
    chk("model_lfsr1", 32'(exp_q[1]), 32'h10);
    chk("model_lfsr2", 32'(exp_q[2]), 32'h18);
    build_exp(2, 6);
    chk("model_walk4", 32'(exp_q[4]), 32'h10);
    chk("model_walk5", 32'(exp_q[5]), 32'h01);
    build_exp(0, 5);
    chk("model_inc4_in_a", 32'(exp_q[4][4:2]), 32'd1);

    run(0, 5, 0, -1);
    run(1, 3, 0, -1);
    run(1, 3, 0, -1);
    run(2, 6, 1, -1);
    run(0, 0, 0, -1);
    run(0, 8, 1, 3);
    run(3, 4, 1, -1);
    run(0, 40, 0, -1);

    // Asynchronous reset in the middle of a run.
    build_exp(0, 8);
    hs_cnt  = 0;
    d0      = done_cnt;
    start   = 1'b1;
    mode    = 2'd0;
    num_vec = 16'd8;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit   = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk); #1;
      if (vec_cnt == 16'd2) hit = 1;
    end
    chk("mid_run_reached", 32'(hit), 32'd1);
    reset_1 = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_vec_cnt", 32'(vec_cnt), 32'd0);
    chk("arst_word", 32'(p_word), 32'd0);
    exp_q.delete();
    #13 reset_1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    run(1, 3, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
